// File: rtl/piece_commit.sv
// piece_commit: validates alu candidate positions against the board, commits
// legal moves, locks blocked drops, clears full rows and spawns new pieces.
module piece_commit #(
    parameter int WIDTH      = 8,
    parameter int MEM_WIDTH  = 10,
    parameter int MEM_HEIGHT = 20,
    parameter int SPAWN_X    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            move_valid,
    output logic                            move_ready,
    input  logic [WIDTH-1:0]                action,
    input  logic [4*WIDTH-1:0]              cand_rho_x,
    input  logic [4*WIDTH-1:0]              cand_rho_y,
    output logic [4*WIDTH-1:0]              rho_x,
    output logic [4*WIDTH-1:0]              rho_y,
    output logic [MEM_HEIGHT*MEM_WIDTH-1:0] board,
    output logic                            move_done,
    output logic                            move_ok,
    output logic [15:0]                     lines,
    output logic                            game_over
);

    localparam int COL_W = (MEM_WIDTH  > 1) ? $clog2(MEM_WIDTH)  : 1;
    localparam int ROW_W = (MEM_HEIGHT > 1) ? $clog2(MEM_HEIGHT) : 1;

    localparam logic [WIDTH-1:0] X_LIM     = WIDTH'(MEM_WIDTH);
    localparam logic [WIDTH-1:0] Y_LIM     = WIDTH'(MEM_HEIGHT);
    localparam logic [WIDTH-1:0] ACT_DOWN  = WIDTH'(1);
    localparam logic [COL_W-1:0] SPAWN_COL = COL_W'(SPAWN_X);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(MEM_HEIGHT - 1);

    typedef enum logic [2:0] {
        SPAWN,
        IDLE,
        CHECK,
        LOCK,
        CLEAR,
        OVER
    } state_t;

    state_t state;
    state_t state_next;

    logic [MEM_WIDTH-1:0] grid [MEM_HEIGHT];
    logic [WIDTH-1:0]     act_q;
    logic [4*WIDTH-1:0]   cand_x_q;
    logic [4*WIDTH-1:0]   cand_y_q;
    logic [4*WIDTH-1:0]   rho_x_q;
    logic [4*WIDTH-1:0]   rho_y_q;
    logic [ROW_W-1:0]     row_q;
    logic [15:0]          lines_q;
    logic                 done_q;
    logic                 ok_q;

    logic [WIDTH-1:0]     cx [4];
    logic [WIDTH-1:0]     cy [4];
    logic [WIDTH-1:0]     px [4];
    logic [WIDTH-1:0]     py [4];

    logic                 cand_legal;
    logic                 spawn_free;
    logic                 row_full;

    // Unpack the per-cell coordinates and flatten the grid onto the board port.
    for (genvar k = 0; k < 4; k++) begin : g_cell
        assign cx[k] = cand_x_q[k*WIDTH +: WIDTH];
        assign cy[k] = cand_y_q[k*WIDTH +: WIDTH];
        assign px[k] = rho_x_q[k*WIDTH +: WIDTH];
        assign py[k] = rho_y_q[k*WIDTH +: WIDTH];
    end

    for (genvar r = 0; r < MEM_HEIGHT; r++) begin : g_row
        assign board[r*MEM_WIDTH +: MEM_WIDTH] = grid[r];
    end

    assign rho_x     = rho_x_q;
    assign rho_y     = rho_y_q;
    assign lines     = lines_q;
    assign move_done = done_q;
    assign move_ok   = ok_q;

    // Legality of the latched candidate; bounds gate the board lookup so an
    // out-of-range coordinate never selects a cell.
    always_comb begin
        cand_legal = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            if (cx[k] >= X_LIM || cy[k] >= Y_LIM) begin
                cand_legal = 1'b0;
            end else if (grid[ROW_W'(cy[k])][COL_W'(cx[k])]) begin
                cand_legal = 1'b0;
            end
        end
    end

    // Spawn column occupancy and the full-row test for the CLEAR scan.
    always_comb begin
        spawn_free = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            if (grid[ROW_W'(k)][SPAWN_COL]) begin
                spawn_free = 1'b0;
            end
        end
        row_full = &grid[row_q];
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SPAWN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_next = state;
        move_ready = 1'b0;
        game_over  = 1'b0;
        unique case (state)
            SPAWN: state_next = spawn_free ? IDLE : OVER;
            IDLE: begin
                move_ready = 1'b1;
                if (move_valid) begin
                    state_next = CHECK;
                end
            end
            CHECK: state_next = (!cand_legal && act_q == ACT_DOWN) ? LOCK : IDLE;
            LOCK:  state_next = CLEAR;
            CLEAR: begin
                if (!row_full && row_q == '0) begin
                    state_next = SPAWN;
                end
            end
            OVER:    game_over  = 1'b1;
            default: state_next = SPAWN;
        endcase
    end

    // Datapath: candidate latch, commit, lock, row clearing and spawn placement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MEM_HEIGHT; i++) begin
                grid[ROW_W'(i)] <= '0;
            end
            act_q    <= '0;
            cand_x_q <= '0;
            cand_y_q <= '0;
            rho_x_q  <= '0;
            rho_y_q  <= '0;
            row_q    <= '0;
            lines_q  <= '0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                SPAWN: begin
                    if (spawn_free) begin
                        rho_x_q <= {4{WIDTH'(SPAWN_X)}};
                        rho_y_q <= {WIDTH'(0), WIDTH'(1), WIDTH'(2), WIDTH'(3)};
                    end
                end
                IDLE: begin
                    if (move_valid) begin
                        act_q    <= action;
                        cand_x_q <= cand_rho_x;
                        cand_y_q <= cand_rho_y;
                    end
                end
                CHECK: begin
                    done_q <= 1'b1;
                    ok_q   <= cand_legal;
                    if (cand_legal) begin
                        rho_x_q <= cand_x_q;
                        rho_y_q <= cand_y_q;
                    end
                end
                LOCK: begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        grid[ROW_W'(py[k])][COL_W'(px[k])] <= 1'b1;
                    end
                    row_q <= LAST_ROW;
                end
                CLEAR: begin
                    if (row_full) begin
                        // Row index stays put: the row shifted in must be tested too.
                        for (int unsigned i = 1; i < MEM_HEIGHT; i++) begin
                            if (ROW_W'(i) <= row_q) begin
                                grid[ROW_W'(i)] <= grid[ROW_W'(i - 1)];
                            end
                        end
                        grid[0] <= '0;
                        if (lines_q != '1) begin
                            lines_q <= lines_q + 16'd1;
                        end
                    end else if (row_q != '0) begin
                        row_q <= row_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
